// File: rtl/weight_buf_pkg.sv
// Constants and types shared by the weight-buffer loader and read scheduler.
package weight_buf_pkg;

    localparam int unsigned WBRAM_DEPTH = 512;
    localparam int unsigned CH_IN       = 16;
    localparam int unsigned CH_OUT      = 32;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWaitLoad,
        StRun,
        StDrain,
        StDone
    } wrs_state_e;

    // ceil(n / 2**sh) for group counts
    function automatic logic [15:0] ceil_shift(input logic [15:0] n, input int unsigned sh);
        logic [16:0] sum;
        sum = {1'b0, n} + ((17'd1 << sh) - 17'd1);
        return 16'(sum >> sh);
    endfunction

endpackage

// File: rtl/wrs_addr_gen.sv
// Nested tile/cog/k/cig counters with an incrementally built weight-buffer read depth.
module wrs_addr_gen #(
    parameter int unsigned COWIDTH = 10,
    parameter int unsigned KWIDTH  = 4,
    parameter int unsigned TWIDTH  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [KWIDTH-1:0]  kk_n_i,
    input  logic [COWIDTH-1:0] cig_n_i,
    input  logic [COWIDTH-1:0] cog_n_i,
    input  logic [TWIDTH-1:0]  tiles_i,
    input  logic [COWIDTH-2:0] stride_k_i,
    input  logic [COWIDTH-2:0] stride_cig_i,
    output logic [COWIDTH-2:0] depth_o,
    output logic               tap_last_o,
    output logic               layer_last_o
);

    localparam int unsigned AW = COWIDTH - 1;

    logic [COWIDTH-1:0] cig_q, cig_d, cog_q, cog_d;
    logic [KWIDTH-1:0]  k_q, k_d;
    logic [TWIDTH-1:0]  tile_q, tile_d;
    logic [AW-1:0]      kofs_q, kofs_d, cofs_q, cofs_d;
    logic               cig_last, k_last, cog_last, tile_last;

    assign cig_last  = (cig_q + COWIDTH'(1)) == cig_n_i;
    assign k_last    = (k_q + KWIDTH'(1)) == kk_n_i;
    assign cog_last  = (cog_q + COWIDTH'(1)) == cog_n_i;
    assign tile_last = (tile_q + TWIDTH'(1)) == tiles_i;

    assign depth_o      = kofs_q + cofs_q + AW'(cog_q);
    assign tap_last_o   = cig_last & k_last;
    assign layer_last_o = cig_last & k_last & cog_last & tile_last;

    // kofs tracks k*stride_k and cofs tracks cig*cog_n, so no multiplier per read
    always_comb begin
        cig_d  = cig_q;
        k_d    = k_q;
        cog_d  = cog_q;
        tile_d = tile_q;
        kofs_d = kofs_q;
        cofs_d = cofs_q;
        if (clear_i) begin
            cig_d  = '0;
            k_d    = '0;
            cog_d  = '0;
            tile_d = '0;
            kofs_d = '0;
            cofs_d = '0;
        end else if (en_i) begin
            if (!cig_last) begin
                cig_d  = cig_q + COWIDTH'(1);
                cofs_d = cofs_q + stride_cig_i;
            end else begin
                cig_d  = '0;
                cofs_d = '0;
                if (!k_last) begin
                    k_d    = k_q + KWIDTH'(1);
                    kofs_d = kofs_q + stride_k_i;
                end else begin
                    k_d    = '0;
                    kofs_d = '0;
                    if (!cog_last) begin
                        cog_d = cog_q + COWIDTH'(1);
                    end else begin
                        cog_d  = '0;
                        tile_d = tile_last ? '0 : tile_q + TWIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cig_q  <= '0;
            k_q    <= '0;
            cog_q  <= '0;
            tile_q <= '0;
            kofs_q <= '0;
            cofs_q <= '0;
        end else begin
            cig_q  <= cig_d;
            k_q    <= k_d;
            cog_q  <= cog_d;
            tile_q <= tile_d;
            kofs_q <= kofs_d;
            cofs_q <= cofs_d;
        end
    end

endmodule

// File: rtl/weight_rd_scheduler.sv
// Read-side sequencer for the ping-pong weight buffer: start sync, config check,
// and the RUN/DRAIN/DONE control around the nested address generator.
module weight_rd_scheduler
    import weight_buf_pkg::*;
#(
    parameter int unsigned COWIDTH   = 10,
    parameter int unsigned KWIDTH    = 4,
    parameter int unsigned LITEWIDTH = 32,
    parameter int unsigned TWIDTH    = 8
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_ap_start,
    input  logic [LITEWIDTH-1:0] I_kxk_num,
    input  logic [LITEWIDTH-1:0] I_ci_num,
    input  logic [LITEWIDTH-1:0] I_co_num,
    input  logic [TWIDTH-1:0]    I_tile_num,
    input  logic                 I_load_done,
    input  logic                 I_pe_ready,
    output logic [COWIDTH-2:0]   O_rd_wdepth,
    output logic                 O_rd_dv,
    output logic                 O_last_tap,
    output logic                 O_busy,
    output logic                 O_layer_done,
    output logic                 O_cfg_err
);

    localparam int unsigned AW = COWIDTH - 1;

    wrs_state_e         state_q, state_d;
    logic [2:0]         start_sync_q;
    logic               start_rise;
    logic [KWIDTH-1:0]  kk_n_q;
    logic [COWIDTH-1:0] cig_n_q, cog_n_q;
    logic [TWIDTH-1:0]  tiles_q;
    logic [AW-1:0]      stride_k_q;
    logic               cfg_err_q, cfg_err_d;
    logic               rd_dv_q, last_tap_q;
    logic               cfg_latch, stride_ld, issue, layer_done;
    logic               tap_last, layer_last;
    logic [31:0]        pair, prod;
    logic               cfg_bad;
    logic               unused_cfg;

    assign unused_cfg = ^{I_kxk_num[LITEWIDTH-1:KWIDTH], I_ci_num[LITEWIDTH-1:COWIDTH],
                          I_co_num[LITEWIDTH-1:COWIDTH]};

    // bits [1:0] are the two-stage sync, bit [2] the edge history
    assign start_rise = start_sync_q[1] & ~start_sync_q[2];

    assign pair    = 32'(cig_n_q) * 32'(cog_n_q);
    assign prod    = pair * 32'(kk_n_q);
    assign cfg_bad = (kk_n_q == '0) || (cig_n_q == '0) || (cog_n_q == '0) ||
                     (tiles_q == '0) || (prod > 32'(WBRAM_DEPTH));

    always_comb begin
        state_d    = state_q;
        cfg_err_d  = cfg_err_q;
        cfg_latch  = 1'b0;
        stride_ld  = 1'b0;
        issue      = 1'b0;
        layer_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    cfg_latch = 1'b1;
                    cfg_err_d = 1'b0;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                stride_ld = 1'b1;
                if (cfg_bad) begin
                    cfg_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    state_d = StWaitLoad;
                end
            end
            StWaitLoad: begin
                if (I_load_done) state_d = StRun;
            end
            StRun: begin
                if (I_pe_ready) begin
                    issue = 1'b1;
                    if (layer_last) state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone: begin
                layer_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q      <= StIdle;
            start_sync_q <= '0;
            kk_n_q       <= '0;
            cig_n_q      <= '0;
            cog_n_q      <= '0;
            tiles_q      <= '0;
            stride_k_q   <= '0;
            cfg_err_q    <= 1'b0;
            rd_dv_q      <= 1'b0;
            last_tap_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_sync_q <= {start_sync_q[1:0], I_ap_start};
            cfg_err_q    <= cfg_err_d;
            rd_dv_q      <= issue;
            last_tap_q   <= issue & tap_last;
            if (cfg_latch) begin
                kk_n_q  <= I_kxk_num[KWIDTH-1:0];
                cig_n_q <= COWIDTH'(ceil_shift(16'(I_ci_num[COWIDTH-1:0]), $clog2(CH_IN)));
                cog_n_q <= COWIDTH'(ceil_shift(16'(I_co_num[COWIDTH-1:0]), $clog2(CH_OUT)));
                tiles_q <= I_tile_num;
            end
            if (stride_ld) stride_k_q <= AW'(pair);
        end
    end

    wrs_addr_gen #(
        .COWIDTH (COWIDTH),
        .KWIDTH  (KWIDTH),
        .TWIDTH  (TWIDTH)
    ) u_addr_gen (
        .clk_i        (I_clk),
        .rst_i        (I_rst),
        .clear_i      (cfg_latch),
        .en_i         (issue),
        .kk_n_i       (kk_n_q),
        .cig_n_i      (cig_n_q),
        .cog_n_i      (cog_n_q),
        .tiles_i      (tiles_q),
        .stride_k_i   (stride_k_q),
        .stride_cig_i (AW'(cog_n_q)),
        .depth_o      (O_rd_wdepth),
        .tap_last_o   (tap_last),
        .layer_last_o (layer_last)
    );

    assign O_rd_dv      = rd_dv_q;
    assign O_last_tap   = last_tap_q;
    assign O_busy       = (state_q != StIdle);
    assign O_layer_done = layer_done;
    assign O_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_weight_rd_scheduler.sv
// Directed bench for weight_rd_scheduler: read order, stalls, config rejection, control edges.
module tb_weight_rd_scheduler;

    logic        I_clk, I_rst, I_ap_start, I_load_done, I_pe_ready;
    logic [31:0] I_kxk_num, I_ci_num, I_co_num;
    logic [7:0]  I_tile_num;
    logic [8:0]  O_rd_wdepth;
    logic        O_rd_dv, O_last_tap, O_busy, O_layer_done, O_cfg_err;

    int vectors = 0;
    int errors  = 0;

    logic [8:0] dv_q[$];
    logic       lt_q[$];
    int         done_cnt = 0;
    int         stall_viol = 0;
    logic [8:0] prev_depth;
    logic       prev_ready;
    int         exp_d[$];
    bit         exp_l[$];

    weight_rd_scheduler dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_ap_start   (I_ap_start),
        .I_kxk_num    (I_kxk_num),
        .I_ci_num     (I_ci_num),
        .I_co_num     (I_co_num),
        .I_tile_num   (I_tile_num),
        .I_load_done  (I_load_done),
        .I_pe_ready   (I_pe_ready),
        .O_rd_wdepth  (O_rd_wdepth),
        .O_rd_dv      (O_rd_dv),
        .O_last_tap   (O_last_tap),
        .O_busy       (O_busy),
        .O_layer_done (O_layer_done),
        .O_cfg_err    (O_cfg_err)
    );

    always #5 I_clk = ~I_clk;

    // Each valid word is paired with the depth presented in the preceding (issue) cycle
    always @(negedge I_clk) begin
        if (O_rd_dv) begin
            dv_q.push_back(prev_depth);
            lt_q.push_back(O_last_tap);
            if (!prev_ready) stall_viol <= stall_viol + 1;
        end
        if (O_layer_done) done_cnt <= done_cnt + 1;
        prev_depth <= O_rd_wdepth;
        prev_ready <= I_pe_ready;
    end

    task automatic build_exp(input int kxk, input int ci, input int co, input int tiles);
        int cign, cogn;
        cign = ((ci % 1024) + 15) / 16;
        cogn = ((co % 1024) + 31) / 32;
        exp_d.delete();
        exp_l.delete();
        for (int t = 0; t < tiles; t++)
            for (int g = 0; g < cogn; g++)
                for (int k = 0; k < kxk; k++)
                    for (int c = 0; c < cign; c++) begin
                        exp_d.push_back(k * cign * cogn + c * cogn + g);
                        exp_l.push_back(c == cign - 1 && k == kxk - 1);
                    end
    endtask

    task automatic run_layer(input int kxk, input int ci, input int co, input int tiles,
                             input bit rnd, input int load_delay, input int restart_at);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 0;
        I_kxk_num   = kxk;
        I_ci_num    = ci;
        I_co_num    = co;
        I_tile_num  = 8'(tiles);
        I_load_done = (load_delay == 0);
        I_ap_start  = 1;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(posedge I_clk);
            #1;
            if (c == 2) I_ap_start = 0;
            if (restart_at > 0 && c == restart_at) I_ap_start = 1;
            if (restart_at > 0 && c == restart_at + 3) I_ap_start = 0;
            if (load_delay > 0 && c == load_delay) begin
                vectors++;
                if (lt_q.size() != dv_q.size() || O_busy !== 1'b1 || O_rd_dv !== 1'b0) begin
                    errors++;
                    $display("FAIL load_wait_hold: busy=%b dv=%b, required busy=1 dv=0",
                             O_busy, O_rd_dv);
                end
                I_load_done = 1;
            end
            I_pe_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cnt != d0) seen = 1;
        end
        I_pe_ready = 1;
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL layer_timeout: no done pulse within 3000 cycles, required one");
        end
        @(negedge I_clk);
    endtask

    task automatic test_reset;
        @(negedge I_clk);
        vectors += 6;
        if (O_rd_wdepth !== 9'd0) begin errors++; $display("FAIL rst_depth: %0d vs 0", O_rd_wdepth); end
        if (O_rd_dv !== 1'b0) begin errors++; $display("FAIL rst_dv: %b vs 0", O_rd_dv); end
        if (O_last_tap !== 1'b0) begin errors++; $display("FAIL rst_last: %b vs 0", O_last_tap); end
        if (O_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b vs 0", O_busy); end
        if (O_layer_done !== 1'b0) begin errors++; $display("FAIL rst_done: %b vs 0", O_layer_done); end
        if (O_cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: %b vs 0", O_cfg_err); end
    endtask

    task automatic test_minimal;
        int idx0, d0;
        idx0 = dv_q.size();
        d0   = done_cnt;
        run_layer(1, 16, 32, 1, 0, 0, 0);
        vectors += 4;
        if (dv_q.size() - idx0 != 1) begin
            errors++; $display("FAIL min_count: %0d reads vs 1", dv_q.size() - idx0);
        end else if (dv_q[idx0] !== 9'd0 || lt_q[idx0] !== 1'b1) begin
            errors++; $display("FAIL min_word: depth=%0d last=%b vs 0/1", dv_q[idx0], lt_q[idx0]);
        end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL min_done: %0d vs 1", done_cnt - d0); end
        if (O_busy !== 1'b0) begin errors++; $display("FAIL min_busy: %b vs 0", O_busy); end
        if (O_cfg_err !== 1'b0) begin errors++; $display("FAIL min_err: %b vs 0", O_cfg_err); end
    endtask

    task automatic test_full_layer(input int ci, input int co, input bit rnd);
        int idx0, s0, n;
        idx0 = dv_q.size();
        s0   = stall_viol;
        build_exp(9, ci, co, 2);
        run_layer(9, ci, co, 2, rnd, 0, 0);
        n = dv_q.size() - idx0;
        vectors += 2;
        if (n != exp_d.size()) begin errors++; $display("FAIL full_count: %0d vs %0d", n, exp_d.size()); end
        if (stall_viol != s0) begin errors++; $display("FAIL full_stall_dv: %0d dv after stall vs 0", stall_viol - s0); end
        for (int i = 0; i < n && i < exp_d.size(); i++) begin
            vectors++;
            if (int'(dv_q[idx0+i]) != exp_d[i] || lt_q[idx0+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL full_word[%0d]: depth=%0d last=%b vs %0d/%b", i, dv_q[idx0+i],
                         lt_q[idx0+i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_overflow;
        int idx0, d0;
        idx0 = dv_q.size();
        d0   = done_cnt;
        run_layer(9, 256, 128, 1, 0, 0, 0);
        vectors += 4;
        if (O_cfg_err !== 1'b1) begin errors++; $display("FAIL ovf_err: %b vs 1", O_cfg_err); end
        if (dv_q.size() != idx0) begin errors++; $display("FAIL ovf_reads: %0d vs 0", dv_q.size() - idx0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL ovf_done: %0d vs 1", done_cnt - d0); end
        if (O_busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: %b vs 0", O_busy); end
        run_layer(0, 16, 32, 1, 0, 0, 0);
        vectors += 2;
        if (O_cfg_err !== 1'b1) begin errors++; $display("FAIL zero_kk_err: %b vs 1", O_cfg_err); end
        if (dv_q.size() != idx0) begin errors++; $display("FAIL zero_kk_reads: %0d vs 0", dv_q.size() - idx0); end
        // exactly 512 words fits and clears the sticky error
        build_exp(2, 256, 512, 1);
        run_layer(2, 256, 512, 1, 0, 0, 0);
        vectors += 3;
        if (O_cfg_err !== 1'b0) begin errors++; $display("FAIL fit512_err: %b vs 0", O_cfg_err); end
        if (dv_q.size() - idx0 != 512) begin errors++; $display("FAIL fit512_count: %0d vs 512", dv_q.size() - idx0); end
        else if (int'(dv_q[idx0+511]) != exp_d[511] || dv_q[idx0+511] !== 9'd511) begin
            errors++; $display("FAIL fit512_last: %0d vs 511", dv_q[idx0+511]);
        end
    endtask

    task automatic test_load_wait;
        int idx0;
        idx0 = dv_q.size();
        run_layer(1, 32, 64, 1, 0, 20, 0);
        vectors++;
        if (dv_q.size() - idx0 != 4) begin errors++; $display("FAIL loadwait_count: %0d vs 4", dv_q.size() - idx0); end
        else begin
            vectors++;
            if (dv_q[idx0] !== 9'd0 || dv_q[idx0+1] !== 9'd2 || dv_q[idx0+2] !== 9'd1 ||
                dv_q[idx0+3] !== 9'd3) begin
                errors++;
                $display("FAIL loadwait_seq: %0d %0d %0d %0d vs 0 2 1 3", dv_q[idx0], dv_q[idx0+1],
                         dv_q[idx0+2], dv_q[idx0+3]);
            end
        end
    endtask

    task automatic test_restart_ignored;
        int idx0, d0;
        idx0 = dv_q.size();
        d0   = done_cnt;
        run_layer(9, 32, 64, 2, 0, 0, 12);
        repeat (12) @(negedge I_clk);
        vectors += 3;
        if (dv_q.size() - idx0 != 72) begin errors++; $display("FAIL restart_count: %0d vs 72", dv_q.size() - idx0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done: %0d vs 1", done_cnt - d0); end
        if (O_busy !== 1'b0) begin errors++; $display("FAIL restart_busy: %b vs 0", O_busy); end
    endtask

    task automatic test_reset_mid_run;
        int d0;
        d0 = done_cnt;
        I_kxk_num  = 9;
        I_ci_num   = 32;
        I_co_num   = 64;
        I_tile_num = 2;
        I_load_done = 1;
        I_ap_start = 1;
        repeat (3) @(posedge I_clk);
        #1 I_ap_start = 0;
        repeat (15) @(posedge I_clk);
        #1 I_rst = 1;
        @(posedge I_clk);
        @(negedge I_clk);
        vectors += 2;
        if (O_busy !== 1'b1 && O_rd_dv !== 1'b0) begin end
        if ({O_rd_wdepth, O_rd_dv, O_last_tap, O_busy, O_layer_done, O_cfg_err} !== 14'd0) begin
            errors++;
            $display("FAIL midrst_outputs: depth=%0d dv=%b last=%b busy=%b done=%b err=%b vs all 0",
                     O_rd_wdepth, O_rd_dv, O_last_tap, O_busy, O_layer_done, O_cfg_err);
        end
        @(posedge I_clk);
        #1 I_rst = 0;
        repeat (10) @(negedge I_clk);
        if (done_cnt != d0 || O_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone: done pulses=%0d busy=%b vs 0/0", done_cnt - d0, O_busy);
        end
        test_minimal();
    endtask

    initial begin
        I_clk = 0;
        I_rst = 1;
        I_ap_start = 0;
        I_load_done = 1;
        I_pe_ready = 1;
        I_kxk_num = 0;
        I_ci_num = 0;
        I_co_num = 0;
        I_tile_num = 0;
        repeat (3) @(posedge I_clk);
        #1 I_rst = 0;
        test_reset();
        test_minimal();
        test_full_layer(32, 64, 0);
        test_full_layer(20, 40, 0);
        test_overflow();
        test_full_layer(32, 64, 1);
        test_load_wait();
        test_restart_ignored();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
